// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and a per-register load scoreboard.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wa_en,
  input  logic [AW-1:0]        wa_addr,
  input  logic [XLEN-1:0]      wa_data,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [CW-1:0]        busy_cnt
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic wa_v, wb_v, rsv_v, same, inc, dec;
  always_comb begin
    wa_v = wa_en && wa_addr != '0;
    wb_v = wb_en && wb_addr != '0;
    rsv_v = rsv_en && rsv_addr != '0;
    same = rsv_v && wb_v && rsv_addr == wb_addr;
    inc = rsv_v && !busy_q[rsv_addr];
    dec = wb_v && !same && busy_q[wb_addr];
    regs_d = regs_q;
    busy_d = busy_q;
    if (wa_v) regs_d[wa_addr] = wa_data;
    if (wb_v) regs_d[wb_addr] = wb_data;
    if (wb_v && !same) busy_d[wb_addr] = 1'b0;
    if (rsv_v) busy_d[rsv_addr] = 1'b1;
    busy_cnt_d = busy_cnt_q + CW'(inc) - CW'(dec);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  assign busy_cnt = busy_cnt_q;
  // Bypass is masked during reset so outputs read as zero while rst is held.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic hit_a, hit_b;
    assign a = ra[i*AW +: AW];
    assign hit_b = !rst && wb_en && wb_addr == a;
    assign hit_a = !rst && wa_en && wa_addr == a;
    assign rd[i*XLEN +: XLEN] = a == '0 ? '0 : hit_b ? wb_data : hit_a ? wa_data : regs_q[a];
    assign rd_busy[i] = a != '0 && (hit_b ? (rsv_en && rsv_addr == a) : busy_q[a]);
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomised checks of regfile_mp against a scoreboard of expected values.
module tb_regfile_mp;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [9:0]   a_ra = '0;
  logic [63:0]  a_rd;
  logic [1:0]   a_rb;
  logic         a_wa_en = 1'b0, a_wb_en = 1'b0, a_rsv_en = 1'b0;
  logic [4:0]   a_wa_addr = '0, a_wb_addr = '0, a_rsv_addr = '0;
  logic [31:0]  a_wa_data = '0, a_wb_data = '0;
  logic [5:0]   a_cnt;
  logic [11:0]  b_ra = '0;
  logic [191:0] b_rd;
  logic [2:0]   b_rb;
  logic         b_wa_en = 1'b0, b_wb_en = 1'b0, b_rsv_en = 1'b0;
  logic [3:0]   b_wa_addr = '0, b_wb_addr = '0, b_rsv_addr = '0;
  logic [63:0]  b_wa_data = '0, b_wb_data = '0;
  logic [4:0]   b_cnt;

  regfile_mp u_a (
    .clk(clk), .rst(rst), .ra(a_ra), .rd(a_rd), .rd_busy(a_rb),
    .wa_en(a_wa_en), .wa_addr(a_wa_addr), .wa_data(a_wa_data),
    .wb_en(a_wb_en), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .busy_cnt(a_cnt)
  );
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) u_b (
    .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd), .rd_busy(b_rb),
    .wa_en(b_wa_en), .wa_addr(b_wa_addr), .wa_data(b_wa_data),
    .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .busy_cnt(b_cnt)
  );

  typedef struct {
    string tag;
    logic [63:0] exp;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_fail = 0;
  logic [63:0] m_regs [16];
  logic [15:0] m_busy = '0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
      return;
    end
    e = q.pop_front();
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic a_cyc(input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                       input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic rse, input logic [4:0] rsa, input logic [4:0] r0, input logic [4:0] r1);
    @(posedge clk);
    #1;
    a_wa_en = wae; a_wa_addr = waa; a_wa_data = wad;
    a_wb_en = wbe; a_wb_addr = wba; a_wb_data = wbd;
    a_rsv_en = rse; a_rsv_addr = rsa;
    a_ra = {r1, r0};
  endtask

  task automatic b_commit;
    if (b_wa_en && b_wa_addr != 4'd0) m_regs[b_wa_addr] = b_wa_data;
    if (b_wb_en && b_wb_addr != 4'd0) begin
      m_regs[b_wb_addr] = b_wb_data;
      if (!(b_rsv_en && b_rsv_addr == b_wb_addr)) m_busy[b_wb_addr] = 1'b0;
    end
    if (b_rsv_en && b_rsv_addr != 4'd0) m_busy[b_rsv_addr] = 1'b1;
  endtask

  task automatic b_cyc(input logic rse, input logic [3:0] rsa, input logic wbe, input logic [3:0] wba);
    logic [3:0] a;
    logic [63:0] d;
    logic bz;
    @(posedge clk);
    #1;
    b_commit();
    b_rsv_en = rse; b_rsv_addr = rsa;
    b_wb_en = wbe; b_wb_addr = wba; b_wb_data = {$urandom(), $urandom()};
    b_wa_en = 1'($urandom_range(0, 1));
    b_wa_addr = 4'($urandom_range(0, 15));
    b_wa_data = {$urandom(), $urandom()};
    b_ra = {4'($urandom_range(0, 15)), rsa, wbe ? wba : 4'($urandom_range(0, 15))};
    for (int p = 0; p < 3; p++) begin
      a = b_ra[p*4 +: 4];
      if (a == 4'd0) begin
        d = '0; bz = 1'b0;
      end else if (wbe && wba == a) begin
        d = b_wb_data; bz = rse && rsa == a;
      end else if (b_wa_en && b_wa_addr == a) begin
        d = b_wa_data; bz = m_busy[a];
      end else begin
        d = m_regs[a]; bz = m_busy[a];
      end
      push($sformatf("b_rd%0d", p), d);
      push($sformatf("b_busy%0d", p), 64'(bz));
    end
    push("b_cnt", 64'($countones(m_busy)));
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      chk(b_rd[p*64 +: 64]);
      chk(64'(b_rb[p]));
    end
    chk(64'(b_cnt));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    #2;
    push("rst_cnt", 0); push("rst_rd0", 0);
    chk(64'(a_cnt)); chk(a_rd[31:0]);
    #10 rst = 1'b0;
    a_cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 7);
    push("byp_r5", 64'hDEADBEEF);
    @(negedge clk); chk(a_rd[31:0]);
    a_cyc(0, 0, 0, 0, 0, 0, 1, 7, 5, 7);
    push("st_r5", 64'hDEADBEEF); push("rsv_not_yet", 0);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_rb[1]));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    push("busy_r7", 1); push("cnt_r7", 1);
    @(negedge clk); chk(64'(a_rb[1])); chk(64'(a_cnt));
    rst = 1'b1;
    #1;
    push("arst_rd", 0); push("arst_busy", 0); push("arst_cnt", 0);
    chk(a_rd[31:0]); chk(64'(a_rb[1])); chk(64'(a_cnt));
    rst = 1'b0;
    a_cyc(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0);
    push("r0_rd", 0); push("r0_busy", 0);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_rb[0]));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("r0_rd_after", 0); push("r0_cnt", 0);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_cnt));
    a_cyc(1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 3, 3);
    push("prio_p0", 64'h22); push("prio_p1", 64'h22);
    @(negedge clk); chk(a_rd[31:0]); chk(a_rd[63:32]);
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    push("r3_stored", 64'h22);
    @(negedge clk); chk(a_rd[31:0]);
    a_cyc(1, 4, 32'h55, 0, 0, 0, 0, 0, 4, 3);
    push("wa_byp_r4", 64'h55); push("r3_keep", 64'h22);
    @(negedge clk); chk(a_rd[31:0]); chk(a_rd[63:32]);
    a_cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    push("r9_busy_pre", 0); push("cnt_pre", 0);
    @(negedge clk); chk(64'(a_rb[0])); chk(64'(a_cnt));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    push("r9_busy", 1); push("cnt_r9", 1);
    @(negedge clk); chk(64'(a_rb[0])); chk(64'(a_cnt));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    a_cyc(0, 0, 0, 1, 9, 32'hCAFE, 0, 0, 9, 0);
    push("ret_byp", 64'hCAFE); push("ret_busy", 0); push("cnt_before_edge", 1);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_rb[0])); chk(64'(a_cnt));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    push("cnt_after_ret", 0); push("r9_stored", 64'hCAFE);
    @(negedge clk); chk(64'(a_cnt)); chk(a_rd[31:0]);
    a_cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    a_cyc(0, 0, 0, 1, 9, 32'hA, 1, 9, 9, 0);
    push("sim_byp", 64'hA); push("sim_busy", 1); push("sim_cnt", 1);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_rb[0])); chk(64'(a_cnt));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    push("sim_data", 64'hA); push("sim_stays_busy", 1); push("sim_cnt_keep", 1);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_rb[0])); chk(64'(a_cnt));
    a_cyc(0, 0, 0, 1, 9, 32'hB, 1, 10, 9, 10);
    push("wb9_byp", 64'hB); push("wb9_busy", 0); push("r10_not_yet", 0);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_rb[0])); chk(64'(a_rb[1]));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
    push("cnt_swap", 1); push("r9_clear", 0); push("r10_set", 1); push("r9_data", 64'hB);
    @(negedge clk); chk(64'(a_cnt)); chk(64'(a_rb[0])); chk(64'(a_rb[1])); chk(a_rd[31:0]);
    rst = 1'b1;
    #1;
    push("midop_cnt", 0);
    chk(64'(a_cnt));
    rst = 1'b0;
    a_cyc(0, 0, 0, 1, 10, 32'h77, 0, 0, 10, 0);
    push("post_rst_byp", 64'h77); push("post_rst_busy", 0);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_rb[0]));
    a_cyc(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    push("post_rst_data", 64'h77); push("post_rst_cnt", 0);
    @(negedge clk); chk(a_rd[31:0]); chk(64'(a_cnt));
    for (int i = 1; i < 16; i++) b_cyc(1'b1, 4'(i), 1'b0, 4'd0);
    b_cyc(1'b0, 4'd0, 1'b0, 4'd0);
    push("b_cnt15", 15);
    chk(64'(b_cnt));
    for (int i = 1; i < 16; i++) b_cyc(1'b0, 4'd0, 1'b1, 4'(i));
    b_cyc(1'b0, 4'd0, 1'b0, 4'd0);
    push("b_cnt0", 0);
    chk(64'(b_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
